// File: rtl/bc_vector_sequencer.sv
// ============================================================================
// Module   : bc_vector_sequencer
// Brief    : Start/done vector sequencer for the Basic_Concept gate network.
//            Optional golden-model check enabled by `define BC_SEQ_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bc_vector_sequencer #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [5:0]       first_vec,
    input  logic [5:0]       last_vec,
    input  logic             y1,
    input  logic             y2,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             e,
    output logic             f,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] y1_ones,
    output logic [CNT_W-1:0] y2_ones,
    output logic [7:0]       sig,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [3:0] c_SETTLE = 4'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_WAIT   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       vec_q, vec_d;
    logic [5:0]       last_q, last_d;
    logic [3:0]       wait_q, wait_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] y1_ones_q, y1_ones_d;
    logic [CNT_W-1:0] y2_ones_q, y2_ones_d;
    logic [7:0]       sig_q, sig_d;
    logic             w_mismatch;

`ifdef BC_SEQ_CHECK_EN
    logic [CNT_W-1:0] err_q, err_d;
    logic             w_exp_y1, w_exp_y2;

    assign w_exp_y1   = vec_q[5] ^ (|vec_q[3:1]);
    assign w_exp_y2   = ~vec_q[4] & (|vec_q[3:1]) & vec_q[0];
    assign w_mismatch = {y1, y2} != {w_exp_y1, w_exp_y2};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    always_comb begin
        err_d = err_q;
        if (!abort) begin
            if (state_q == S_IDLE && start) begin
                err_d = '0;
            end else if (state_q == S_SAMPLE && w_mismatch) begin
                err_d = err_q + CNT_W'(1);
            end
        end
    end

    assign err_cnt = err_q;
`else
    assign w_mismatch = 1'b0;
    assign err_cnt    = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            vec_q     <= '0;
            last_q    <= '0;
            wait_q    <= '0;
            vec_cnt_q <= '0;
            y1_ones_q <= '0;
            y2_ones_q <= '0;
            sig_q     <= '0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            last_q    <= last_d;
            wait_q    <= wait_d;
            vec_cnt_q <= vec_cnt_d;
            y1_ones_q <= y1_ones_d;
            y2_ones_q <= y2_ones_d;
            sig_q     <= sig_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        last_d    = last_q;
        wait_d    = wait_q;
        vec_cnt_d = vec_cnt_q;
        y1_ones_d = y1_ones_q;
        y2_ones_d = y2_ones_q;
        sig_d     = sig_q;
        // abort freezes every result register, even on a SAMPLE cycle
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        vec_d     = first_vec;
                        last_d    = last_vec;
                        vec_cnt_d = '0;
                        y1_ones_d = '0;
                        y2_ones_d = '0;
                        sig_d     = '0;
                        state_d   = S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    wait_d  = c_SETTLE;
                    state_d = (SETTLE == 0) ? S_SAMPLE : S_WAIT;
                end
                S_WAIT: begin
                    wait_d = wait_q - 4'd1;
                    if (wait_q <= 4'd1) begin
                        state_d = S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    vec_cnt_d = vec_cnt_q + CNT_W'(1);
                    y1_ones_d = y1_ones_q + CNT_W'(y1);
                    y2_ones_d = y2_ones_q + CNT_W'(y2);
                    sig_d     = {sig_q[6:0], 1'b0} ^ (sig_q[7] ? 8'h1D : 8'h00)
                              ^ {6'b0, y1, y2};
                    if (vec_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        vec_d   = vec_q + 6'd1;
                        state_d = S_DRIVE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign {a, b, c, d, e, f} = vec_q;
    assign busy    = state_q != S_IDLE;
    assign done    = state_q == S_DONE;
    assign vec_cnt = vec_cnt_q;
    assign y1_ones = y1_ones_q;
    assign y2_ones = y2_ones_q;
    assign sig     = sig_q;

endmodule

`default_nettype wire
